// File: rtl/fx_writeback_queue.sv
// Writeback queue between FX execute stage 2 and the GPR file / condition register.
// Captures FX results in order, drains them under valid/ready and keeps the architected XER SO/OV/CA bits.
module fx_writeback_queue #(
  parameter int         DEPTH      = 4,
  parameter int         PTR_W      = 2,
  parameter logic [1:0] FXUnitCode = 2'd0
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         fxValid_i,
  input  logic [1:0]   fxUnitCode_i,
  input  logic         is64Bit_i,
  input  logic [5:0]   fxAddress_i,
  input  logic [63:0]  fxValue_i,
  input  logic         fxCarry_i,
  input  logic         fxOverflow_i,
  input  logic         fxCrWrite_i,
  output logic         rfWriteEnable_o,
  input  logic         rfWriteReady_i,
  output logic [5:0]   rfWriteAddress_o,
  output logic [63:0]  rfWriteValue_o,
  output logic         cr0Write_o,
  output logic [3:0]   cr0Bits_o,
  output logic         xerSO_o,
  output logic         xerOV_o,
  output logic         xerCA_o,
  output logic [PTR_W:0] count_o,
  output logic         full_o,
  output logic         dropError_o
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [5:0]  addr;
    logic [63:0] value;
    logic        is64;
    logic        carry;
    logic        overflow;
    logic        cr_write;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  logic             xer_so_q, xer_ov_q, xer_ca_q;
  logic             drop_q;
  logic             not_empty, full;
  logic             push_req, do_enq, do_deq;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign push_req  = fxValid_i && (fxUnitCode_i == FXUnitCode);
  assign do_deq    = not_empty && rfWriteReady_i;
  assign do_enq    = push_req && (!full || do_deq);
  assign head      = mem[head_q];

  // NOTE: storage carries no reset; count_q alone decides which slots are meaningful,
  // and leaving the array unreset keeps it a plain register file / RAM.
  always_ff @(posedge clock_i) begin
    if (do_enq) begin
      mem[tail_q] <= '{addr: fxAddress_i, value: fxValue_i, is64: is64Bit_i,
                       carry: fxCarry_i, overflow: fxOverflow_i, cr_write: fxCrWrite_i};
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      xer_so_q <= 1'b0;
      xer_ov_q <= 1'b0;
      xer_ca_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (do_enq) tail_q <= tail_q + PTR_W'(1);
      if (do_deq) begin
        head_q   <= head_q + PTR_W'(1);
        xer_ca_q <= head.carry;
        xer_ov_q <= head.overflow;
        xer_so_q <= xer_so_q | head.overflow;
      end
      if (do_enq && !do_deq)      count_q <= count_q + (PTR_W+1)'(1);
      else if (!do_enq && do_deq) count_q <= count_q - (PTR_W+1)'(1);
      if (push_req && full && !do_deq) drop_q <= 1'b1;
    end
  end

  // Value is big-endian numbered: architected bit 0 is [63], bit 32 is [31],
  // so the 32b low word is [31:0].
  logic sign_bit, is_zero;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sign_bit  = 1'b0;
    is_zero   = 1'b0;
    cr0Bits_o = 4'b0000;
    if (not_empty) begin
      sign_bit  = head.is64 ? head.value[63] : head.value[31];
      is_zero   = head.is64 ? (head.value == 64'd0) : (head.value[31:0] == 32'd0);
      cr0Bits_o = {sign_bit, !sign_bit && !is_zero, is_zero, xer_so_q | head.overflow};
    end
  end

  assign rfWriteEnable_o  = not_empty;
  assign rfWriteAddress_o = not_empty ? head.addr  : 6'd0;
  assign rfWriteValue_o   = not_empty ? head.value : 64'd0;
  assign cr0Write_o       = not_empty && head.cr_write;
  assign xerSO_o          = xer_so_q;
  assign xerOV_o          = xer_ov_q;
  assign xerCA_o          = xer_ca_q;
  assign count_o          = count_q;
  assign full_o           = full;
  assign dropError_o      = drop_q;

endmodule

// File: tb/tb_fx_writeback_queue.sv
// Directed bench for fx_writeback_queue: ordering, full/drop, wrap, CR0 and XER behaviour.
module tb_fx_writeback_queue;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        fxValid_i;
  logic [1:0]  fxUnitCode_i;
  logic        is64Bit_i;
  logic [5:0]  fxAddress_i;
  logic [63:0] fxValue_i;
  logic        fxCarry_i, fxOverflow_i, fxCrWrite_i;
  logic        rfWriteEnable_o, rfWriteReady_i;
  logic [5:0]  rfWriteAddress_o;
  logic [63:0] rfWriteValue_o;
  logic        cr0Write_o;
  logic [3:0]  cr0Bits_o;
  logic        xerSO_o, xerOV_o, xerCA_o;
  logic [2:0]  count_o;
  logic        full_o, dropError_o;

  int checks   = 0;
  int failures = 0;

  fx_writeback_queue #(.DEPTH(4), .PTR_W(2), .FXUnitCode(2'd0)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .fxValid_i(fxValid_i), .fxUnitCode_i(fxUnitCode_i),
    .is64Bit_i(is64Bit_i), .fxAddress_i(fxAddress_i), .fxValue_i(fxValue_i),
    .fxCarry_i(fxCarry_i), .fxOverflow_i(fxOverflow_i), .fxCrWrite_i(fxCrWrite_i),
    .rfWriteEnable_o(rfWriteEnable_o), .rfWriteReady_i(rfWriteReady_i),
    .rfWriteAddress_o(rfWriteAddress_o), .rfWriteValue_o(rfWriteValue_o),
    .cr0Write_o(cr0Write_o), .cr0Bits_o(cr0Bits_o), .xerSO_o(xerSO_o), .xerOV_o(xerOV_o),
    .xerCA_o(xerCA_o), .count_o(count_o), .full_o(full_o), .dropError_o(dropError_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic set_result(input logic [5:0] addr, input logic [63:0] value, input logic is64,
                            input logic carry, input logic ovf, input logic crw, input logic [1:0] unit);
    fxValid_i    = 1'b1;
    fxAddress_i  = addr;
    fxValue_i    = value;
    is64Bit_i    = is64;
    fxCarry_i    = carry;
    fxOverflow_i = ovf;
    fxCrWrite_i  = crw;
    fxUnitCode_i = unit;
  endtask

  task automatic push(input logic [5:0] addr, input logic [63:0] value, input logic is64,
                      input logic carry, input logic ovf, input logic crw);
    set_result(addr, value, is64, carry, ovf, crw, 2'd0);
    tick();
    fxValid_i = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [5:0] addr, input logic [63:0] value);
    check({tag, "_we"},   64'(rfWriteEnable_o), 64'd1);
    check({tag, "_addr"}, 64'(rfWriteAddress_o), 64'(addr));
    check({tag, "_val"},  rfWriteValue_o, value);
  endtask

  initial begin
    reset_i        = 1'b0;
    fxValid_i      = 1'b0;
    fxUnitCode_i   = 2'd0;
    is64Bit_i      = 1'b1;
    fxAddress_i    = '0;
    fxValue_i      = '0;
    fxCarry_i      = 1'b0;
    fxOverflow_i   = 1'b0;
    fxCrWrite_i    = 1'b0;
    rfWriteReady_i = 1'b0;
    tick();
    tick();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_we",    64'(rfWriteEnable_o), 64'd0);
    check("rst_xer",   64'({xerSO_o, xerOV_o, xerCA_o}), 64'd0);
    check("rst_cr0",   64'(cr0Bits_o), 64'd0);
    check("rst_full",  64'(full_o), 64'd0);
    reset_i = 1'b1;
    tick();

    // Single record-form result; visible one cycle after capture, drained next edge.
    rfWriteReady_i = 1'b1;
    push(6'd5, 64'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    check_head("t2", 6'd5, 64'h10);
    check("t2_cr0",   64'(cr0Bits_o), 64'b0100);
    check("t2_cr0w",  64'(cr0Write_o), 64'd1);
    check("t2_count", 64'(count_o), 64'd1);
    tick();
    check("t2_empty_we",  64'(rfWriteEnable_o), 64'd0);
    check("t2_empty_cnt", 64'(count_o), 64'd0);
    check("t2_empty_cr0", 64'(cr0Bits_o), 64'd0);
    check("t2_xer",       64'({xerSO_o, xerOV_o, xerCA_o}), 64'd0);

    // Fill with ready low: four accepted, fifth dropped.
    rfWriteReady_i = 1'b0;
    for (int i = 1; i <= 4; i++) push(6'(i), 64'(i * 256), 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_full4",  64'(full_o), 64'd1);
    check("t3_nodrop", 64'(dropError_o), 64'd0);
    push(6'd5, 64'h500, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_count", 64'(count_o), 64'd4);
    check("t3_drop",  64'(dropError_o), 64'd1);
    check_head("t3_head", 6'd1, 64'h100);
    tick();
    check_head("t3_stall", 6'd1, 64'h100);

    // Full queue with dequeue and push on the same edge.
    rfWriteReady_i = 1'b1;
    push(6'd6, 64'h600, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_count", 64'(count_o), 64'd4);
    check("t4_full",  64'(full_o), 64'd1);
    check_head("t4_h2", 6'd2, 64'h200);
    tick();
    check_head("t4_h3", 6'd3, 64'h300);
    tick();
    check_head("t4_h4", 6'd4, 64'h400);
    tick();
    check_head("t4_h6", 6'd6, 64'h600);
    tick();
    check("t4_empty", 64'(rfWriteEnable_o), 64'd0);

    // 32b negative result with overflow, then a zero result without.
    rfWriteReady_i = 1'b0;
    push(6'd7, 64'h00000000_80000000, 1'b0, 1'b1, 1'b1, 1'b1);
    push(6'd8, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_cr0a",  64'(cr0Bits_o), 64'b1001);
    check("t5_xer0",  64'({xerSO_o, xerOV_o, xerCA_o}), 64'b000);
    rfWriteReady_i = 1'b1;
    tick();
    check("t5_xera",  64'({xerSO_o, xerOV_o, xerCA_o}), 64'b111);
    check("t5_cr0b",  64'(cr0Bits_o), 64'b0011);
    tick();
    check("t5_xerb",  64'({xerSO_o, xerOV_o, xerCA_o}), 64'b100);
    check("t5_empty", 64'(count_o), 64'd0);

    // 32b mode uses only the low word: upper ones ignored, low word positive.
    rfWriteReady_i = 1'b0;
    push(6'd9, 64'hFFFFFFFF_00000001, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_cr0c", 64'(cr0Bits_o), 64'b0101);
    rfWriteReady_i = 1'b1;
    tick();
    rfWriteReady_i = 1'b0;

    // Foreign unit code and idle valid-low cycles never enqueue.
    set_result(6'd10, 64'h1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    tick();
    fxValid_i = 1'b0;
    fxUnitCode_i = 2'd0;
    tick();
    check("t6_count", 64'(count_o), 64'd0);
    check("t6_we",    64'(rfWriteEnable_o), 64'd0);

    // Reset mid-stream with three entries queued.
    for (int i = 0; i < 3; i++) push(6'(20 + i), 64'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_pre", 64'(count_o), 64'd3);
    #2 reset_i = 1'b0;
    tick();
    check("t1_count", 64'(count_o), 64'd0);
    check("t1_we",    64'(rfWriteEnable_o), 64'd0);
    check("t1_xer",   64'({xerSO_o, xerOV_o, xerCA_o}), 64'd0);
    check("t1_drop",  64'(dropError_o), 64'd0);
    reset_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
